recurrence_sequencer: RTL and testbench

RECURRENCE_SEQUENCER -- requirements
Module: recurrence_sequencer

---
 rtl/seq_pkg.sv | 24 ++
 rtl/recurrence_sequencer_if.sv | 31 +++
 rtl/seq_step_counter.sv | 35 +++
 rtl/recurrence_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_recurrence_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared ALU opcodes, FSM state encoding and register constants for recurrence_sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_ADD  = 3'b010
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP_SUM,
        S_UP_SHIFT,
        S_DN_SUB,
        S_DN_SHIFT,
        S_DONE,
        S_ERR
    } seq_state_e;

    // Sliced to the select width at the point of use; all-ones means "no register".
    localparam logic [31:0] NO_REG = '1;

endpackage

// File: rtl/recurrence_sequencer_if.sv
// rtl/recurrence_sequencer_if.sv - control/status and datapath-select bundle of recurrence_sequencer
interface recurrence_sequencer_if #(
    parameter int SELECTIONDECO = 3,
    parameter int SELECTIONALU  = 3,
    parameter int CNT_W         = 8
);
    logic                     start;
    logic [CNT_W-1:0]         iter_cnt;
    logic                     sOverflow;
    logic                     sCarry;
    logic                     sNegative;
    logic                     sZero;
    logic [SELECTIONDECO-1:0] sSelDecoA;
    logic [SELECTIONDECO-1:0] sSelDecoB;
    logic [SELECTIONDECO-1:0] sSelDecoC;
    logic [SELECTIONALU-1:0]  sSelAlu;
    logic                     busy;
    logic                     done;
    logic                     err;

    // master: the sequencer; slave: the controller/datapath side
    modport master (
        input  start, iter_cnt, sOverflow, sCarry, sNegative, sZero,
        output sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, busy, done, err
    );

    modport slave (
        output start, iter_cnt, sOverflow, sCarry, sNegative, sZero,
        input  sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, busy, done, err
    );
endinterface

// File: rtl/seq_step_counter.sv
// rtl/seq_step_counter.sv - step down-counter with load, decrement, zero and one flags
module seq_step_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             lowRst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             one
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge lowRst) begin
        if (lowRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/recurrence_sequencer.sv
// rtl/recurrence_sequencer.sv - steps a K-term recurrence forward N times then back N times on a register-file datapath
// Optional SEQ_OVF_CHECK_EN: overflow/carry during the forward sum aborts into ERR.
module recurrence_sequencer
    import seq_pkg::*;
#(
    parameter int SELECTIONDECO = 3,
    parameter int SELECTIONALU  = 3,
    parameter int NUM_TERMS     = 3,
    parameter int TAP_P         = 2,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  lowRst,
    recurrence_sequencer_if.master bus
);
    localparam int IDX_W = $clog2(NUM_TERMS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);

    localparam logic [SELECTIONDECO-1:0] SEL_NONE   = NO_REG[SELECTIONDECO-1:0];
    localparam logic [SELECTIONDECO-1:0] SEL_SEED   = SELECTIONDECO'((1 << SELECTIONDECO) - 2);
    localparam logic [SELECTIONDECO-1:0] SEL_TEMP   = SELECTIONDECO'(NUM_TERMS);
    localparam logic [SELECTIONDECO-1:0] SEL_OLDEST = '0;
    localparam logic [SELECTIONDECO-1:0] SEL_NEWEST = SELECTIONDECO'(NUM_TERMS - 1);
    localparam logic [SELECTIONDECO-1:0] SEL_TAP_UP = SELECTIONDECO'(NUM_TERMS - TAP_P);
    localparam logic [SELECTIONDECO-1:0] SEL_TAP_DN = SELECTIONDECO'(NUM_TERMS - 1 - TAP_P);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;

    logic             cnt_load, cnt_dec, cnt_zero, cnt_one;
    logic [CNT_W-1:0] cnt_load_val;
    logic             last_idx;
    logic             unused_flags;

    seq_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk      (clk),
        .lowRst   (lowRst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

`ifdef SEQ_OVF_CHECK_EN
    assign unused_flags = bus.sNegative ^ bus.sZero;
`else
    assign unused_flags = ^{bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero};
`endif

    assign last_idx = (idx_q == LAST_IDX);
    // The backward pass restarts from the captured N, never from the live input.
    assign cnt_load_val = (state_q == S_UP_SHIFT) ? n_q : bus.iter_cnt;

    always_ff @(posedge clk or posedge lowRst) begin
        if (lowRst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d  = S_LOAD;
                    idx_d    = '0;
                    n_d      = bus.iter_cnt;
                    cnt_load = 1'b1;
                end
            end
            S_LOAD: begin
                idx_d = idx_q + IDX_W'(1);
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = cnt_zero ? S_DONE : S_UP_SUM;
                end
            end
            S_UP_SUM: begin
                idx_d   = '0;
                state_d = S_UP_SHIFT;
`ifdef SEQ_OVF_CHECK_EN
                if (bus.sOverflow || bus.sCarry) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_UP_SHIFT: begin
                idx_d = idx_q + IDX_W'(1);
                if (last_idx) begin
                    idx_d = '0;
                    if (cnt_one) begin
                        cnt_load = 1'b1;
                        state_d  = S_DN_SUB;
                    end else begin
                        cnt_dec  = 1'b1;
                        state_d  = S_UP_SUM;
                    end
                end
            end
            S_DN_SUB: begin
                idx_d   = '0;
                state_d = S_DN_SHIFT;
            end
            S_DN_SHIFT: begin
                idx_d = idx_q + IDX_W'(1);
                if (last_idx) begin
                    idx_d   = '0;
                    cnt_dec = 1'b1;
                    state_d = cnt_one ? S_DONE : S_DN_SUB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [SELECTIONDECO-1:0] sel_a, sel_b, sel_c;
    alu_op_e                  alu_op;
    logic                     busy_o, done_o, err_o;

    always_comb begin
        sel_a  = SEL_NONE;
        sel_b  = SEL_NONE;
        sel_c  = SEL_NONE;
        alu_op = ALU_PASS;
        busy_o = 1'b0;
        done_o = 1'b0;
        err_o  = 1'b0;
        case (state_q)
            S_LOAD: begin
                sel_a  = SEL_SEED;
                sel_c  = SELECTIONDECO'(idx_q);
                busy_o = 1'b1;
            end
            S_UP_SUM: begin
                sel_a  = SEL_TAP_UP;
                sel_b  = SEL_OLDEST;
                sel_c  = SEL_TEMP;
                alu_op = ALU_ADD;
                busy_o = 1'b1;
            end
            S_UP_SHIFT: begin
                sel_a  = SELECTIONDECO'(idx_q) + SELECTIONDECO'(1);
                sel_c  = SELECTIONDECO'(idx_q);
                busy_o = 1'b1;
            end
            S_DN_SUB: begin
                sel_a  = SEL_NEWEST;
                sel_b  = SEL_TAP_DN;
                sel_c  = SEL_TEMP;
                alu_op = ALU_SUB;
                busy_o = 1'b1;
            end
            S_DN_SHIFT: begin
                // Shift toward the newest end; the recovered oldest term lands in R0 last.
                if (last_idx) begin
                    sel_a = SEL_TEMP;
                    sel_c = SEL_OLDEST;
                end else begin
                    sel_c = SEL_NEWEST - SELECTIONDECO'(idx_q);
                    sel_a = sel_c - SELECTIONDECO'(1);
                end
                busy_o = 1'b1;
            end
            S_DONE: done_o = 1'b1;
`ifdef SEQ_OVF_CHECK_EN
            S_ERR: err_o = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.sSelDecoA = sel_a;
    assign bus.sSelDecoB = sel_b;
    assign bus.sSelDecoC = sel_c;
    assign bus.sSelAlu   = SELECTIONALU'(alu_op);
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.err       = err_o;
endmodule

// File: tb/tb_recurrence_sequencer.sv
// tb/tb_recurrence_sequencer.sv - self-checking bench: datapath register-file model plus phase-arithmetic select reference
module tb_recurrence_sequencer;
    localparam int SD = 3;
    localparam int SA = 3;
    localparam int K  = 3;
    localparam int P  = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic lowRst;
    always #5 clk = ~clk;

    recurrence_sequencer_if #(.SELECTIONDECO(SD), .SELECTIONALU(SA), .CNT_W(CW)) bus ();

    recurrence_sequencer #(
        .SELECTIONDECO(SD), .SELECTIONALU(SA), .NUM_TERMS(K), .TAP_P(P), .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .lowRst (lowRst),
        .bus    (bus)
    );

    int          errors = 0;
    int          checks = 0;
    string       cur_tag = "init";
    logic [7:0]  rf [8];
    logic [11:0] golden1 [11];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_tag, name, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] cur_sel();
        return {bus.sSelDecoA, bus.sSelDecoB, bus.sSelDecoC, bus.sSelAlu};
    endfunction

    function automatic logic [31:0] cur_status();
        return 32'({bus.busy, bus.done, bus.err});
    endfunction

    // Expected selects for run cycle c of an N-step run: K load cycles, then N forward
    // steps of (sum + K shifts), then N backward steps of (sub + K shifts).
    function automatic logic [11:0] exp_sel(input int n, input int c);
        logic [2:0] a, b, w, op;
        int s, r, j;
        a = 3'd7; b = 3'd7; w = 3'd7; op = 3'd0;
        if (c < K) begin
            a = 3'd6;
            w = 3'(c);
        end else begin
            s = (c - K) / (K + 1);
            r = (c - K) % (K + 1);
            j = r - 1;
            if (s < n) begin
                if (r == 0) begin
                    a = 3'(K - P); b = 3'd0; w = 3'(K); op = 3'd2;
                end else begin
                    a = 3'(j + 1); w = 3'(j);
                end
            end else begin
                if (r == 0) begin
                    a = 3'(K - 1); b = 3'(K - 1 - P); w = 3'(K); op = 3'd1;
                end else if (j < K - 1) begin
                    w = 3'(K - 1 - j); a = 3'(K - 2 - j);
                end else begin
                    a = 3'(K); w = 3'd0;
                end
            end
        end
        return {a, b, w, op};
    endfunction

    // One clock of the register-file datapath driven by the DUT's current selects.
    task automatic tick();
        logic [7:0] va, vb, res;
        logic [2:0] wsel;
        va   = (bus.sSelDecoA == 3'd7) ? 8'd0 : rf[bus.sSelDecoA];
        vb   = (bus.sSelDecoB == 3'd7) ? 8'd0 : rf[bus.sSelDecoB];
        case (bus.sSelAlu)
            3'd1:    res = va - vb;
            3'd2:    res = va + vb;
            default: res = va;
        endcase
        wsel = bus.sSelDecoC;
        @(posedge clk);
        #1;
        if (wsel != 3'd7) rf[wsel] = res;
    endtask

    task automatic run(input int n, input logic [7:0] seed, input bit noisy, input string tag);
        int L;
        logic [7:0] x [$];
        cur_tag = tag;
        L = K + 2 * n * (K + 1);
        rf[6] = seed;
        x.delete();
        for (int i = 0; i < K; i++) x.push_back(seed);
        for (int i = K; i < n + K; i++) x.push_back(x[i - P] + x[i - K]);
        bus.iter_cnt = 8'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < L; c++) begin
            if (noisy) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.iter_cnt = 8'd9;
            end
`ifndef SEQ_OVF_CHECK_EN
            bus.sOverflow = 1'($urandom_range(0, 1));
            bus.sCarry    = 1'($urandom_range(0, 1));
`endif
            bus.sNegative = 1'($urandom_range(0, 1));
            bus.sZero     = 1'($urandom_range(0, 1));
            chk("sel", 32'(cur_sel()), 32'(exp_sel(n, c)));
            chk("busy", cur_status(), 32'(3'b100));
            if (n == 1) chk("trace", 32'(cur_sel()), 32'(golden1[c]));
            tick();
            if (n > 0 && c == K + n * (K + 1) - 1)
                chk("up_window", 32'({rf[0], rf[1], rf[2]}), 32'({x[n], x[n + 1], x[n + 2]}));
        end
        bus.start = 1'b0;
        bus.sOverflow = 1'b0;
        bus.sCarry = 1'b0;
        chk("done", cur_status(), 32'(3'b010));
        chk("done_sel", 32'(cur_sel()), 32'(12'b111_111_111_000));
        chk("final_window", 32'({rf[0], rf[1], rf[2]}), 32'({seed, seed, seed}));
        tick();
        chk("done_hold", cur_status(), 32'(3'b010));
    endtask

    initial begin
        lowRst = 1'b1;
        bus.start = 1'b0;
        bus.iter_cnt = '0;
        bus.sOverflow = 1'b0;
        bus.sCarry = 1'b0;
        bus.sNegative = 1'b0;
        bus.sZero = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 8'd0;
        golden1[0]  = {3'd6, 3'd7, 3'd0, 3'd0};
        golden1[1]  = {3'd6, 3'd7, 3'd1, 3'd0};
        golden1[2]  = {3'd6, 3'd7, 3'd2, 3'd0};
        golden1[3]  = {3'd1, 3'd0, 3'd3, 3'd2};
        golden1[4]  = {3'd1, 3'd7, 3'd0, 3'd0};
        golden1[5]  = {3'd2, 3'd7, 3'd1, 3'd0};
        golden1[6]  = {3'd3, 3'd7, 3'd2, 3'd0};
        golden1[7]  = {3'd2, 3'd0, 3'd3, 3'd1};
        golden1[8]  = {3'd1, 3'd7, 3'd2, 3'd0};
        golden1[9]  = {3'd0, 3'd7, 3'd1, 3'd0};
        golden1[10] = {3'd3, 3'd7, 3'd0, 3'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel", 32'(cur_sel()), 32'(12'b111_111_111_000));
        chk("reset_status", cur_status(), 32'(3'b000));
        lowRst = 1'b0;
        tick();
        chk("idle_status", cur_status(), 32'(3'b000));

        run(1, 8'd5, 1'b0, "n1");
        run(0, 8'd3, 1'b0, "n0");
        run(4, 8'd1, 1'b0, "n4");
        run(3, 8'd7, 1'b1, "busy_noise");

        cur_tag = "mid_reset";
        bus.iter_cnt = 8'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (K + 2) tick();
        chk("pre_reset_sel", 32'(cur_sel()), 32'(exp_sel(2, K + 2)));
        lowRst = 1'b1;
        #1;
        chk("reset_sel", 32'(cur_sel()), 32'(12'b111_111_111_000));
        chk("reset_status", cur_status(), 32'(3'b000));
        @(posedge clk);
        #1;
        lowRst = 1'b0;
        run(2, 8'd4, 1'b0, "after_reset");

`ifdef SEQ_OVF_CHECK_EN
        cur_tag = "ovf";
        bus.iter_cnt = 8'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (K) tick();
        chk("up_sum_sel", 32'(cur_sel()), 32'(exp_sel(2, K)));
        bus.sOverflow = 1'b1;
        tick();
        bus.sOverflow = 1'b0;
        chk("err_status", cur_status(), 32'(3'b001));
        chk("err_sel", 32'(cur_sel()), 32'(12'b111_111_111_000));
        tick();
        chk("err_hold", cur_status(), 32'(3'b001));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_status", cur_status(), 32'(3'b100));
        chk("restart_sel", 32'(cur_sel()), 32'(exp_sel(2, 0)));
        lowRst = 1'b1;
        #1;
        lowRst = 1'b0;
`endif

        for (int r = 0; r < 4; r++) begin
            run(int'($urandom_range(0, 5)), 8'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
